// File: rtl/pseudo_lru_pkg.sv
// Shared types and tree helpers for the heap-indexed pseudo-LRU replacement unit.
// Trees are carried at a fixed maximum size; callers pass their real way count.
package pseudo_lru_pkg;

   localparam int PLRU_MAX_WAYS  = 64;
   localparam int PLRU_MAX_WAY_W = $clog2(PLRU_MAX_WAYS);
   localparam int PLRU_NODE_W    = PLRU_MAX_WAY_W + 1;

   // Bit i holds heap node i; bit 0 is never used.
   typedef logic [PLRU_MAX_WAYS-1:0]  plru_tree_t;
   typedef logic [PLRU_MAX_WAYS-1:0]  plru_valid_t;
   typedef logic [PLRU_MAX_WAY_W-1:0] plru_way_t;
   typedef logic [PLRU_NODE_W-1:0]    plru_node_t;

   function automatic plru_way_t plru_victim(input plru_tree_t  tree,
                                             input plru_valid_t valid,
                                             input plru_node_t  num_ways);
      plru_node_t node;
      plru_way_t  way;
      logic       found;
      found = 1'b0;
      way   = '0;
      for (int w = 0; w < PLRU_MAX_WAYS; w++) begin
         if (!found && (plru_node_t'(w) < num_ways) && !valid[w]) begin
            found = 1'b1;
            way   = plru_way_t'(w);
         end
      end
      // Walk: child index is 2*node + bit, i.e. shift in the node's bit.
      node = plru_node_t'(1);
      for (int l = 0; l < PLRU_MAX_WAY_W; l++) begin
         if (node < num_ways)
            node = {node[PLRU_MAX_WAY_W-1:0], tree[node[PLRU_MAX_WAY_W-1:0]]};
      end
      if (!found)
         way = plru_way_t'(node - num_ways);
      return way;
   endfunction

   function automatic plru_tree_t plru_update(input plru_tree_t tree,
                                              input plru_way_t  way,
                                              input plru_node_t num_ways);
      plru_tree_t t;
      plru_node_t node;
      t    = tree;
      node = num_ways + {1'b0, way};
      // Climb from the leaf; a left child (even index) makes its parent point right.
      for (int l = 0; l < PLRU_MAX_WAY_W; l++) begin
         if (node > plru_node_t'(1)) begin
            t[node[PLRU_NODE_W-1:1]] = ~node[0];
            node = node >> 1;
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/pseudo_lru_tree.sv
// Combinational view of one PLRU tree: invalid-first victim walk on walk_tree and
// a single-way MRU update applied to base_tree.
module pseudo_lru_tree #(
   parameter int NUM_WAYS = 8,
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:1] walk_tree,
   input  logic [NUM_WAYS-1:0] way_valid,
   input  logic [NUM_WAYS-1:1] base_tree,
   input  logic                upd_use_victim,
   input  logic [WAY_W-1:0]    upd_way,
   output logic [WAY_W-1:0]    victim_way,
   output logic [NUM_WAYS-1:1] upd_tree
);
   import pseudo_lru_pkg::*;

   localparam plru_node_t WAYS_N = plru_node_t'(NUM_WAYS);

   plru_tree_t  walk_ext;
   plru_tree_t  base_ext;
   plru_tree_t  upd_ext;
   plru_valid_t valid_ext;
   plru_way_t   victim_ext;
   plru_way_t   upd_sel;
   logic        unused_ext;

   always_comb begin
      walk_ext                  = '0;
      walk_ext[NUM_WAYS-1:1]    = walk_tree;
      base_ext                  = '0;
      base_ext[NUM_WAYS-1:1]    = base_tree;
      valid_ext                 = '1;
      valid_ext[NUM_WAYS-1:0]   = way_valid;
      victim_ext                = plru_victim(walk_ext, valid_ext, WAYS_N);
      upd_sel                   = upd_use_victim ? victim_ext : plru_way_t'(upd_way);
      upd_ext                   = plru_update(base_ext, upd_sel, WAYS_N);
   end

   assign victim_way = victim_ext[WAY_W-1:0];
   assign upd_tree   = upd_ext[NUM_WAYS-1:1];

   // Bits beyond this tree's size are don't-care.
   assign unused_ext = ^{upd_ext, victim_ext};

endmodule

// File: rtl/pseudo_lru_array.sv
// Per-set tree pseudo-LRU state with touch/commit updates and a registered,
// invalid-first victim answer one cycle after each request.
module pseudo_lru_array #(
   parameter int NUM_WAYS = 8,
   parameter int NUM_SETS = 16,
   parameter int WAY_W    = $clog2(NUM_WAYS),
   parameter int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                touch,
   input  logic [SET_W-1:0]    touch_set,
   input  logic [WAY_W-1:0]    touch_way,
   input  logic                victim_req,
   input  logic [SET_W-1:0]    victim_set,
   input  logic [NUM_WAYS-1:0] way_valid,
   input  logic                victim_commit,
   input  logic                flush,
   output logic                victim_valid,
   output logic [WAY_W-1:0]    victim_way
);
   import pseudo_lru_pkg::*;

   localparam logic [SET_W:0] SET_LIM = (SET_W+1)'(NUM_SETS);

   logic [NUM_WAYS-1:1] tree_q [NUM_SETS];

   logic                touch_ok;
   logic                vset_ok;
   logic                commit_ok;
   logic                same_set;
   logic [SET_W-1:0]    tset_eff;
   logic [SET_W-1:0]    vset_eff;
   logic [NUM_WAYS-1:1] vtree;
   logic [NUM_WAYS-1:1] ttree;
   logic [NUM_WAYS-1:1] touched_tree;
   logic [NUM_WAYS-1:1] commit_base;
   logic [NUM_WAYS-1:1] committed_tree;
   logic [WAY_W-1:0]    victim_p0;
   logic [WAY_W-1:0]    unused_touch_victim;
   logic                vld_p1;
   logic [WAY_W-1:0]    way_p1;

   // ---- stage p0: set decode, victim walk and tree updates
   assign touch_ok  = touch && ({1'b0, touch_set} < SET_LIM);
   assign vset_ok   = {1'b0, victim_set} < SET_LIM;
   assign tset_eff  = touch_ok ? touch_set : '0;
   assign vset_eff  = vset_ok ? victim_set : '0;
   assign commit_ok = victim_req && victim_commit && vset_ok;
   assign same_set  = touch_ok && (touch_set == victim_set);

   assign vtree = tree_q[vset_eff];
   assign ttree = tree_q[tset_eff];

   // Commit lands on top of a same-set touch, so it wins on shared nodes.
   assign commit_base = same_set ? touched_tree : vtree;

   pseudo_lru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_touch_tree (
      .walk_tree      (ttree),
      .way_valid      ({NUM_WAYS{1'b1}}),
      .base_tree      (ttree),
      .upd_use_victim (1'b0),
      .upd_way        (touch_way),
      .victim_way     (unused_touch_victim),
      .upd_tree       (touched_tree)
   );

   pseudo_lru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_victim_tree (
      .walk_tree      (vtree),
      .way_valid      (way_valid),
      .base_tree      (commit_base),
      .upd_use_victim (1'b1),
      .upd_way        ('0),
      .victim_way     (victim_p0),
      .upd_tree       (committed_tree)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tree_q <= '{default: '0};
      end else if (flush) begin
         tree_q <= '{default: '0};
      end else begin
         if (touch_ok)
            tree_q[tset_eff] <= touched_tree;
         if (commit_ok)
            tree_q[vset_eff] <= committed_tree;
      end
   end

   // ---- stage p1: registered victim answer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         way_p1 <= '0;
      end else begin
         vld_p1 <= victim_req;
         if (victim_req)
            way_p1 <= victim_p0;
      end
   end

   assign victim_valid = vld_p1;
   assign victim_way   = way_p1;

   a_touch_set_range: assert property (@(posedge clk) disable iff (!rst_n)
      touch |-> touch_ok);
   a_victim_set_range: assert property (@(posedge clk) disable iff (!rst_n)
      victim_req |-> vset_ok);

endmodule

// File: tb/tb_pseudo_lru_array.sv
// Bench for pseudo_lru_array: directed scenarios and random traffic checked against
// a recency-timestamp model (each subtree's LRU half is the one touched longest ago).
module tb_pseudo_lru_array;

   localparam int NW = 8;
   localparam int NS = 16;
   localparam int WW = 3;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          touch;
   logic [SW-1:0] touch_set;
   logic [WW-1:0] touch_way;
   logic          victim_req;
   logic [SW-1:0] victim_set;
   logic [NW-1:0] way_valid;
   logic          victim_commit;
   logic          flush;
   logic          victim_valid;
   logic [WW-1:0] victim_way;

   pseudo_lru_array #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .touch         (touch),
      .touch_set     (touch_set),
      .touch_way     (touch_way),
      .victim_req    (victim_req),
      .victim_set    (victim_set),
      .way_valid     (way_valid),
      .victim_commit (victim_commit),
      .flush         (flush),
      .victim_valid  (victim_valid),
      .victim_way    (victim_way)
   );

   always #5 clk = ~clk;

   int unsigned   last_use [NS][NW];
   int unsigned   stamp;
   logic          exp_vld;
   logic [WW-1:0] exp_way;
   int            n_cmp;
   int            n_bad;
   int            s1_exp [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

   function automatic int model_victim(input int s, input logic [NW-1:0] valid);
      int          lo;
      int          size;
      int          half;
      int unsigned ml;
      int unsigned mr;
      for (int w = 0; w < NW; w++)
         if (!valid[w]) return w;
      lo   = 0;
      size = NW;
      while (size > 1) begin
         half = size / 2;
         ml   = 0;
         mr   = 0;
         for (int k = 0; k < half; k++) begin
            if (last_use[SW'(s)][WW'(lo + k)] > ml)        ml = last_use[SW'(s)][WW'(lo + k)];
            if (last_use[SW'(s)][WW'(lo + half + k)] > mr) mr = last_use[SW'(s)][WW'(lo + half + k)];
         end
         if (ml > mr) lo = lo + half;
         size = half;
      end
      return lo;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++)
            last_use[s][w] = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      touch         = 1'b0;
      touch_set     = '0;
      touch_way     = '0;
      victim_req    = 1'b0;
      victim_set    = '0;
      way_valid     = '1;
      victim_commit = 1'b0;
      flush         = 1'b0;
   endtask

   // One clock of stimulus; the model advances at the edge and both outputs are checked.
   task automatic step(input logic t, input int tset, input int tway,
                       input logic r, input int vset, input logic [NW-1:0] vv,
                       input logic c, input logic f);
      int v;
      touch         = t;
      touch_set     = SW'(tset);
      touch_way     = WW'(tway);
      victim_req    = r;
      victim_set    = SW'(vset);
      way_valid     = vv;
      victim_commit = c;
      flush         = f;
      v = model_victim(vset, vv);
      @(posedge clk);
      if (f) begin
         model_clear();
      end else begin
         if (t) begin
            stamp++;
            last_use[SW'(tset)][WW'(tway)] = stamp;
         end
         if (r && c) begin
            stamp++;
            last_use[SW'(vset)][WW'(v)] = stamp;
         end
      end
      exp_vld = r;
      if (r) exp_way = WW'(v);
      #1;
      check("valid", 32'(victim_valid), 32'(exp_vld));
      check("way", 32'(victim_way), 32'(exp_way));
      clear_inputs();
   endtask

   task automatic tch(input int s, input int w);
      step(1'b1, s, w, 1'b0, 0, '1, 1'b0, 1'b0);
   endtask

   task automatic req(input int s, input logic [NW-1:0] vv, input logic c);
      step(1'b0, 0, 0, 1'b1, s, vv, c, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_clear();
      exp_vld = 1'b0;
      exp_way = '0;
      @(posedge clk);
      #1;
      check("rst_valid", 32'(victim_valid), 32'd0);
      check("rst_way", 32'(victim_way), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      stamp = 0;

      // Commit-driven sweep of set 0 visits every way once before repeating.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req(0, '1, 1'b1);
         check("sweep", 32'(victim_way), 32'(s1_exp[i]));
      end

      // A request in the flush cycle still sees the pre-flush tree.
      step(1'b0, 0, 0, 1'b1, 0, '1, 1'b0, 1'b1);
      check("flush_pre", 32'(victim_way), 32'd4);
      req(0, '1, 1'b0);
      check("flush_post", 32'(victim_way), 32'd0);

      // Touch then plain requests leave the tree alone.
      do_reset();
      tch(0, 0);
      req(0, '1, 1'b0);
      check("touch0_a", 32'(victim_way), 32'd4);
      req(0, '1, 1'b0);
      check("touch0_b", 32'(victim_way), 32'd4);

      // Invalid way chosen first, and its commit steers the next walk.
      req(2, 8'b1111_0111, 1'b1);
      check("invalid_first", 32'(victim_way), 32'd3);
      req(2, '1, 1'b0);
      check("after_inv_commit", 32'(victim_way), 32'd4);

      // Sets are independent.
      for (int w = 0; w < 4; w++) tch(3, w);
      req(5, '1, 1'b0);
      check("iso_set5", 32'(victim_way), 32'd0);
      req(3, '1, 1'b0);
      check("iso_set3", 32'(victim_way), 32'd4);

      // Same-cycle touch and commit: victim from the old tree, commit applied last.
      do_reset();
      step(1'b1, 0, 4, 1'b1, 0, '1, 1'b1, 1'b0);
      check("tc_victim", 32'(victim_way), 32'd0);
      req(0, '1, 1'b0);
      check("tc_next", 32'(victim_way), 32'd6);
      step(1'b0, 0, 0, 1'b0, 0, '1, 1'b0, 1'b0);
      check("hold_way", 32'(victim_way), 32'd6);
      check("hold_valid", 32'(victim_valid), 32'd0);

      // Reset asserted while a request waits for its edge drops it.
      victim_req = 1'b1;
      victim_set = '0;
      way_valid  = '1;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_drop_valid", 32'(victim_valid), 32'd0);
      check("rst_drop_way", 32'(victim_way), 32'd0);
      clear_inputs();
      model_clear();
      exp_vld = 1'b0;
      exp_way = '0;
      rst_n   = 1'b1;

      // Asynchronous reset clears a result that is already on the outputs.
      tch(1, 0);
      req(1, '1, 1'b0);
      check("pre_async", 32'(victim_way), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", 32'(victim_valid), 32'd0);
      check("async_way", 32'(victim_way), 32'd0);

      // Random traffic against the recency model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         logic          t;
         logic          r;
         logic          c;
         logic          f;
         int            ts;
         int            tw;
         int            vs;
         logic [NW-1:0] vv;
         t  = ($urandom_range(0, 1) == 1);
         r  = ($urandom_range(0, 9) < 6);
         c  = ($urandom_range(0, 1) == 1);
         f  = ($urandom_range(0, 60) == 0);
         ts = int'($urandom_range(0, 3));
         tw = int'($urandom_range(0, NW - 1));
         vs = ($urandom_range(0, 2) == 0) ? ts : int'($urandom_range(0, 3));
         vv = ($urandom_range(0, 3) != 0) ? '1 : NW'($urandom);
         step(t, ts, tw, r, vs, vv, c, f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
